laser_tx_framer: RTL

- Packet framer directly upstream of the laser transmitter.
- Buffers a payload byte stream from the host side, then emits SYNC, LEN, payload bytes and CSUM one byte at a time.
- Uses the transmitter's byte handshake: data_ready is a 1-cycle pulse, and the transmitter returns a 1-cycle done.
- Aborts cleanly if the link enable drops mid-packet.

---
 rtl/laser_tx_framer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/laser_tx_framer.sv
// laser_tx_framer: collects one payload packet from the host stream, then sends
// SYNC, LEN, payload and CSUM to the laser transmitter, one byte per
// data_ready/done handshake, followed by a forced idle gap.
module laser_tx_framer #(
  parameter int unsigned MAX_LEN  = 64,
  parameter logic [7:0]  SYNC     = 8'hA5,
  parameter int unsigned IDLE_GAP = 4
) (
  input  logic       clock_base,
  input  logic       reset,
  input  logic       link_en,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_done,
  output logic       busy,
  output logic       pkt_sent,
  output logic       pkt_aborted
);

  localparam int unsigned LEN_W    = $clog2(MAX_LEN + 1);
  localparam int unsigned ADDR_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned IDX_W    = 9;
  localparam int unsigned GAP_W    = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
  localparam int unsigned GAP_LAST = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   len, len_nxt;
  logic [7:0]         sum, sum_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic               load_tx;
  logic               sent_c;
  logic               abort_c;
  logic               accept_c;
  logic               tx_valid_q;
  logic [7:0]         tx_byte;
  logic [7:0]         buffer [MAX_LEN];

  assign accept_c = in_valid && in_ready;

  // The transmitter must never see data_ready while the link is down.
  assign tx_valid = tx_valid_q && link_en;

  // Next-state, counters and one-cycle event decode.
  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    sum_nxt   = sum;
    idx_nxt   = idx;
    gap_nxt   = gap_cnt;
    load_tx   = 1'b0;
    sent_c    = 1'b0;
    abort_c   = 1'b0;
    case (state)
      S_IDLE, S_FILL: begin
        if (accept_c) begin
          len_nxt = len + LEN_W'(1);
          sum_nxt = sum + in_data;
          if (in_last || (len == LEN_W'(MAX_LEN - 1))) begin
            state_nxt = S_ISSUE;
            idx_nxt   = '0;
            load_tx   = 1'b1;
          end else begin
            state_nxt = S_FILL;
          end
        end
      end
      S_ISSUE: begin
        if (!link_en) begin
          state_nxt = S_IDLE;
          abort_c   = 1'b1;
          len_nxt   = '0;
          sum_nxt   = '0;
          idx_nxt   = '0;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!link_en) begin
          state_nxt = S_IDLE;
          abort_c   = 1'b1;
          len_nxt   = '0;
          sum_nxt   = '0;
          idx_nxt   = '0;
        end else if (tx_done) begin
          if (idx < (IDX_W'(len) + IDX_W'(2))) begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = S_ISSUE;
            load_tx   = 1'b1;
          end else begin
            state_nxt = S_GAP;
            sent_c    = 1'b1;
            len_nxt   = '0;
            sum_nxt   = '0;
            idx_nxt   = '0;
            gap_nxt   = '0;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_W'(GAP_LAST)) begin
          state_nxt = S_IDLE;
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Selects the wire byte for the index about to be issued.
  always_comb begin
    tx_byte = buffer[ADDR_W'(idx_nxt - IDX_W'(2))];
    if (idx_nxt == '0) begin
      tx_byte = SYNC;
    end else if (idx_nxt == IDX_W'(1)) begin
      tx_byte = 8'(len);
    end else if (idx_nxt == (IDX_W'(len) + IDX_W'(2))) begin
      tx_byte = 8'(len) + sum;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock_base or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      len         <= '0;
      sum         <= '0;
      idx         <= '0;
      gap_cnt     <= '0;
      in_ready    <= 1'b1;
      tx_data     <= '0;
      tx_valid_q  <= 1'b0;
      busy        <= 1'b0;
      pkt_sent    <= 1'b0;
      pkt_aborted <= 1'b0;
    end else begin
      state       <= state_nxt;
      len         <= len_nxt;
      sum         <= sum_nxt;
      idx         <= idx_nxt;
      gap_cnt     <= gap_nxt;
      in_ready    <= (state_nxt == S_IDLE) || (state_nxt == S_FILL);
      tx_valid_q  <= (state_nxt == S_ISSUE);
      busy        <= (state_nxt != S_IDLE);
      pkt_sent    <= sent_c;
      pkt_aborted <= abort_c;
      if (load_tx) begin
        tx_data <= tx_byte;
      end
    end
  end

  // Payload storage; contents are don't-care after reset.
  always_ff @(posedge clock_base) begin
    if (accept_c) begin
      buffer[ADDR_W'(len)] <= in_data;
    end
  end

endmodule
